// File: rtl/ifetch_queue_pkg.sv
// Shared widths and the fetch-queue entry layout for the instruction fetch stage.
// Memory and queue geometry are fixed here so every file agrees on them.
package ifetch_queue_pkg;

  localparam int INST_LEN      = 32;
  localparam int MEMI_SIZE     = 8;
  localparam int MEMI_SIZE_LOG = 3;
  localparam int PC_LEN        = MEMI_SIZE_LOG + 1;
  localparam int FQ_DEPTH      = 4;
  localparam int FQ_DEPTH_LOG  = 2;
  localparam int FQ_WIDTH      = INST_LEN + MEMI_SIZE_LOG;

  typedef struct packed {
    logic [INST_LEN-1:0]      inst;
    logic [MEMI_SIZE_LOG-1:0] pc;
  } fq_entry_t;

endpackage

// File: rtl/ifetch_queue_sync_fifo.sv
// In-order FIFO with flush; the head entry is read straight from storage (no output
// register) and reads as zero while the FIFO is empty.
module sync_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int DEPTH_LOG = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int CNT_W = DEPTH_LOG + 1;

  logic [WIDTH-1:0]     mem_reg [DEPTH];
  logic [DEPTH_LOG-1:0] head_reg, tail_reg;
  logic [CNT_W-1:0]     count_reg;
  logic                 do_push, do_pop;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? '0 : mem_reg[head_reg];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (flush) begin
      // A pop seen in the flush cycle is dropped along with everything else.
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (do_push) tail_reg <= tail_reg + 1'b1;
      if (do_pop)  head_reg <= head_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_reg[tail_reg] <= wdata;
  end

endmodule

// File: rtl/ifetch_queue.sv
// Fetch stage: owns the PC, reads instruction memory combinationally and queues
// {inst, pc} pairs for decode; a redirect flushes the queue and retargets the PC.
module ifetch_queue
  import ifetch_queue_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  output logic [MEMI_SIZE_LOG-1:0] memi_req_addr,
  input  logic [INST_LEN-1:0]      memi_resp_data,
  input  logic                     redirect_valid,
  input  logic [MEMI_SIZE_LOG-1:0] redirect_pc,
  output logic                     deq_valid,
  input  logic                     deq_ready,
  output logic [INST_LEN-1:0]      deq_inst,
  output logic [MEMI_SIZE_LOG-1:0] deq_pc,
  output logic                     fetch_done
);

  logic [PC_LEN-1:0] pc_reg, pc_next;
  logic              push, pop, fq_full, fq_empty;
  fq_entry_t         wr_entry, rd_entry;

  // The extra PC bit doubles as the "ran off the end of memory" flag.
  assign fetch_done    = pc_reg[MEMI_SIZE_LOG];
  assign memi_req_addr = pc_reg[MEMI_SIZE_LOG-1:0];

  // Full is judged on this cycle's occupancy, so a same-cycle pop never makes room.
  assign push      = !fetch_done && !fq_full && !redirect_valid;
  assign deq_valid = !fq_empty;
  assign pop       = deq_valid && deq_ready;

  assign wr_entry  = '{inst: memi_resp_data, pc: memi_req_addr};
  assign deq_inst  = rd_entry.inst;
  assign deq_pc    = rd_entry.pc;

  always_comb begin
    pc_next = pc_reg;
    if (redirect_valid) pc_next = {1'b0, redirect_pc};
    else if (push)      pc_next = pc_reg + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc_reg <= '0;
    else      pc_reg <= pc_next;
  end

  sync_fifo #(
    .WIDTH     (FQ_WIDTH),
    .DEPTH     (FQ_DEPTH),
    .DEPTH_LOG (FQ_DEPTH_LOG)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (rd_entry),
    .full  (fq_full),
    .empty (fq_empty)
  );

endmodule
